// File: rtl/mult_rs.sv
// Multiply reservation station: holds dispatched multiply ops, wakes their
// sources off the CDB, and issues the oldest fully-ready op to the multiply FU.

// One station slot: operand readiness/values plus the pass-through payload.
module mult_rs_entry #(
  parameter int W    = 8,
  parameter int TAGW = 4,
  parameter int PW   = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 wr,
  input  logic [1:0]           wr_rdy,
  input  logic [1:0][TAGW-1:0] wr_tag,
  input  logic [1:0][W-1:0]    wr_val,
  input  logic [PW-1:0]        wr_pay,
  input  logic                 cdb_valid,
  input  logic [TAGW-1:0]      cdb_id,
  input  logic [W-1:0]         cdb_val,
  output logic                 valid,
  output logic [1:0]           rdy,
  output logic [1:0][W-1:0]    val,
  output logic [PW-1:0]        pay
);
  logic [1:0][TAGW-1:0] tag;

  // Allocate, wake up from CDB, or retire (issue/flush wins over everything).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rdy   <= '0;
      tag   <= '0;
      val   <= '0;
      pay   <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
      pay   <= wr_pay;
      for (int s = 0; s < 2; s++) begin
        tag[s] <= wr_tag[s];
        if (wr_rdy[s]) begin
          rdy[s] <= 1'b1;
          val[s] <= wr_val[s];
        end else if (cdb_valid && wr_tag[s] == cdb_id) begin
          // producer broadcasting in the dispatch cycle: catch it now
          rdy[s] <= 1'b1;
          val[s] <= cdb_val;
        end else begin
          rdy[s] <= 1'b0;
        end
      end
    end else if (valid) begin
      for (int s = 0; s < 2; s++)
        if (!rdy[s] && cdb_valid && tag[s] == cdb_id) begin
          rdy[s] <= 1'b1;
          val[s] <= cdb_val;
        end
    end
  end
endmodule

module mult_rs #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int TAGW  = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 disp_valid,
  input  logic [7:0]           disp_operand,
  input  logic [1:0]           disp_rdy,
  input  logic [1:0][TAGW-1:0] disp_tag,
  input  logic [1:0][W-1:0]    disp_val,
  input  logic [7:0]           disp_wbs,
  input  logic [7:0]           disp_flags,
  input  logic [3:0]           disp_robid,
  output logic                 disp_full,
  input  logic                 cdb_valid,
  input  logic [TAGW-1:0]      cdb_id,
  input  logic [W-1:0]         cdb_val,
  input  logic                 fu_stall,
  output logic                 input_transmit,
  output logic [7:0]           operand,
  output logic [1:0][W-1:0]    depvals,
  output logic [7:0]           wbs,
  output logic [7:0]           flags,
  output logic [3:0]           robid,
  output logic [CW-1:0]        count
);
  localparam int PW = 28;  // {operand, wbs, flags, robid}

  logic [DEPTH-1:0]                valid, cand, wr, issue_oh, clr;
  logic [DEPTH-1:0][1:0]           rdy;
  logic [DEPTH-1:0][1:0][W-1:0]    val;
  logic [DEPTH-1:0][PW-1:0]        pay;
  logic [DEPTH-1:0][DEPTH-1:0]     older;  // older[i][j]: entry i dispatched before j
  logic                            disp_we, issue_en;

  assign disp_full = &valid;
  assign disp_we   = disp_valid & ~disp_full & ~flush;
  assign cand      = valid & {DEPTH{1'b1}} & {rdy_and()};
  assign issue_en  = (|cand) & ~fu_stall & ~flush;
  assign clr       = issue_oh | {DEPTH{flush}};

  function automatic logic [DEPTH-1:0] rdy_and();
    for (int i = 0; i < DEPTH; i++) rdy_and[i] = &rdy[i];
  endfunction

  // Lowest-index free slot takes the dispatch.
  always_comb begin
    logic found;
    wr    = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (!valid[i] && !found) begin
        wr[i] = disp_we;
        found = 1'b1;
      end
  end

  // Oldest candidate: older than every other candidate.
  always_comb begin
    issue_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      issue_oh[i] = cand[i] & issue_en;
      for (int j = 0; j < DEPTH; j++)
        if (j != i && cand[j] && !older[i][j]) issue_oh[i] = 1'b0;
    end
  end

  // Age matrix: a new entry is younger than every entry currently valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older <= '0;
    end else if (flush) begin
      older <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        for (int j = 0; j < DEPTH; j++)
          if (wr[k]) begin
            older[k][j] <= 1'b0;
            older[j][k] <= valid[j];
          end
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      mult_rs_entry #(.W(W), .TAGW(TAGW), .PW(PW)) u_ent (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr[g]),
        .wr        (wr[g]),
        .wr_rdy    (disp_rdy),
        .wr_tag    (disp_tag),
        .wr_val    (disp_val),
        .wr_pay    ({disp_operand, disp_wbs, disp_flags, disp_robid}),
        .cdb_valid (cdb_valid),
        .cdb_id    (cdb_id),
        .cdb_val   (cdb_val),
        .valid     (valid[g]),
        .rdy       (rdy[g]),
        .val       (val[g]),
        .pay       (pay[g])
      );
    end
  endgenerate

  // Issue mux: one-hot OR, all zero when nothing issues.
  always_comb begin
    logic [PW-1:0] p;
    p       = '0;
    depvals = '0;
    for (int i = 0; i < DEPTH; i++)
      if (issue_oh[i]) begin
        p       = p | pay[i];
        depvals = depvals | val[i];
      end
    input_transmit = issue_en;
    {operand, wbs, flags, robid} = p;
  end

  // Occupancy.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(valid[i]);
  end
endmodule
